// File: rtl/xlr8_i2c_eeprom_resp_if.sv
// I2C pin bundle between an initiator (or board model) and the EEPROM responder.
// SDA is open-drain: sda_oe=1 pulls the line low, sda_in is the resolved pin level.
interface xlr8_i2c_eeprom_resp_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;
  logic busy;

  modport slave  (input scl_in, input sda_in, output sda_oe, output busy);
  modport master (output scl_in, output sda_in, input sda_oe, input busy);
endinterface

// File: rtl/xlr8_i2c_eeprom_resp.sv
// 24AA128-style I2C EEPROM responder: 2-byte word address, page write, current/random/sequential read.
// Optional write-protect pin enabled by defining XLR8_I2C_EEPROM_WP_EN.
module xlr8_i2c_eeprom_resp #(
  parameter logic [3:0] DEV_ADDR_HI = 4'b1010,
  parameter int         MEM_AW      = 8,
  parameter int         PAGE_AW     = 6
) (
  input  logic                  Clock,
  input  logic                  RESET_N,
  xlr8_i2c_eeprom_resp_if.slave bus,
  input  logic [2:0]            addr_pins
`ifdef XLR8_I2C_EEPROM_WP_EN
  ,
  input  logic                  wp
`endif
);

  localparam int DEPTH = 2 ** MEM_AW;
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((1 << PAGE_AW) - 1);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_AH, ADDR_LO, ACK_AL,
    WRITE, ACK_WR, READ, RACK, IGNORE
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [MEM_AW-1:0]   ptr_q, ptr_d;
  logic                sda_oe_q, sda_oe_d;
  logic                scl_s1_q, scl_s2_q, scl_d1_q;
  logic                sda_s1_q, sda_s2_q, sda_d1_q;
  logic [7:0]          mem_q [DEPTH];
  logic                mem_we;
  logic                wr_en;

  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d1_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d1_q <= 1'b1;
    end else begin
      scl_s1_q <= bus.scl_in;
      scl_s2_q <= scl_s1_q;
      scl_d1_q <= scl_s2_q;
      sda_s1_q <= bus.sda_in;
      sda_s2_q <= sda_s1_q;
      sda_d1_q <= sda_s2_q;
    end
  end

`ifdef XLR8_I2C_EEPROM_WP_EN
  logic wp_s1_q, wp_s2_q;

  // Protected until the strap has been sampled after reset.
  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      wp_s1_q <= 1'b1;
      wp_s2_q <= 1'b1;
    end else begin
      wp_s1_q <= wp;
      wp_s2_q <= wp_s1_q;
    end
  end

  assign wr_en = ~wp_s2_q;
`else
  assign wr_en = 1'b1;
`endif

  logic             scl_rise, scl_fall, start_det, stop_det;
  logic             byte_done, dev_match;
  logic [7:0]       byte_in, rd_byte;
  logic [MEM_AW-1:0] ptr_page_inc;

  assign scl_rise     = scl_s2_q & ~scl_d1_q;
  assign scl_fall     = ~scl_s2_q & scl_d1_q;
  assign start_det    = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
  assign stop_det     = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;
  assign byte_in      = {shift_q[6:0], sda_s2_q};
  assign byte_done    = scl_rise && (bit_cnt_q == 4'd7);
  assign dev_match    = (byte_in[7:1] == {DEV_ADDR_HI, addr_pins});
  assign rd_byte      = mem_q[ptr_q];
  assign ptr_page_inc = (ptr_q & ~PAGE_MASK) | ((ptr_q + MEM_AW'(1)) & PAGE_MASK);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_hi_d = addr_hi_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    mem_we    = 1'b0;
    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (start_det) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        DEVADDR, ADDR_HI, ADDR_LO, WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (byte_done) begin
            if (state_q == DEVADDR) begin
              state_d = dev_match ? ACK_DEV : IGNORE;
            end else if (state_q == ADDR_HI) begin
              addr_hi_d = byte_in;
              state_d   = ACK_AH;
            end else if (state_q == ADDR_LO) begin
              ptr_d   = MEM_AW'({addr_hi_q, byte_in});
              state_d = ACK_AL;
            end else begin
              mem_we  = wr_en;
              ptr_d   = ptr_page_inc;
              state_d = ACK_WR;
            end
          end
        end
        // bit_cnt 8 -> drive ACK on the next fall; 9 -> release after the 9th clock.
        ACK_DEV, ACK_AH, ACK_AL, ACK_WR: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ACK_DEV && shift_q[0]) begin
              state_d  = READ;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else if (state_q == ACK_DEV) begin
              state_d = ADDR_HI;
            end else if (state_q == ACK_AH) begin
              state_d = ADDR_LO;
            end else begin
              state_d = WRITE;
            end
          end
        end
        READ: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + MEM_AW'(1);
              state_d  = RACK;
            end else begin
              sda_oe_d = ~shift_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            shift_d   = {7'd0, sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            if (shift_q[0]) begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end else begin
              state_d  = READ;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end
          end
        end
        IDLE, IGNORE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_hi_q <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_hi_q <= addr_hi_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  // Storage has no reset; contents are undefined until written.
  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[ptr_q] <= byte_in;
  end

  assign bus.sda_oe = sda_oe_q;
  assign bus.busy   = (state_q != IDLE);

endmodule
